// File: rtl/cam_pkg.sv
// Shared constants and field-filter encodings for the camera crop window.
package cam_pkg;

    localparam int CAM_CNT_W       = 11;
    localparam int CAM_DEF_V_START = 0;
    localparam int CAM_DEF_V_LEN   = 240;
    localparam int CAM_DEF_H_START = 0;
    localparam int CAM_DEF_H_LEN   = 720;

    typedef enum logic [1:0] {
        FS_BOTH = 2'd0,
        FS_EVEN = 2'd1,
        FS_ODD  = 2'd2
    } field_sel_e;

endpackage

// File: rtl/cam_edge_det.sv
// Edge detector built on a registered copy of the input; edges are flagged in the
// cycle the input changes, so downstream state updates on the following clock.
module cam_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    logic sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;
    assign edge_o = sig_i ^ sig_q;

endmodule

// File: rtl/cam_crop_window.sv
// Programmable line/pixel crop window between the capture front end and the line
// buffer, with per-field shadowed configuration and short-line error reporting.
module cam_crop_window #(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = cam_pkg::CAM_CNT_W,
    parameter int DEF_V_START = cam_pkg::CAM_DEF_V_START,
    parameter int DEF_V_LEN   = cam_pkg::CAM_DEF_V_LEN,
    parameter int DEF_H_START = cam_pkg::CAM_DEF_H_START,
    parameter int DEF_H_LEN   = cam_pkg::CAM_DEF_H_LEN,
    parameter int FIELD_SEL   = int'(cam_pkg::FS_BOTH)
) (
    input  logic              cam_pclk,
    input  logic              cam_reset,
    input  logic              in_line_valid,
    input  logic              in_y_valid,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_field_toggle,
    input  logic [CNT_W-1:0]  cfg_v_start,
    input  logic [CNT_W-1:0]  cfg_v_len,
    input  logic [CNT_W-1:0]  cfg_h_start,
    input  logic [CNT_W-1:0]  cfg_h_len,
    output logic              out_line_valid,
    output logic              out_y_valid,
    output logic [DATA_W-1:0] out_y,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_field,
    output logic              err_short_line,
    output logic [7:0]        err_count
);
    import cam_pkg::*;

    localparam int   SUM_W    = CNT_W + 1;
    localparam logic SEL_BOTH = (FIELD_SEL == int'(FS_BOTH));
    localparam logic SEL_EVEN = (FIELD_SEL == int'(FS_EVEN));
    localparam logic SEL_ODD  = (FIELD_SEL == int'(FS_ODD));

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [SUM_W-1:0] sum_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : cnt_t'(v + 1'b1);
    endfunction

    function automatic sum_t ext(input cnt_t v);
        return {1'b0, v};
    endfunction

    logic lv_rise, lv_fall, lv_edge;
    logic f_rise, f_fall, f_edge;

    // NOTE: the line-valid copy resets high so a line already in flight at reset
    // release is not mistaken for a new line start.
    cam_edge_det #(.RST_VAL(1'b1)) u_lv_edge (
        .clk_i(cam_pclk), .rst_i(cam_reset), .sig_i(in_line_valid),
        .rise_o(lv_rise), .fall_o(lv_fall), .edge_o(lv_edge)
    );

    cam_edge_det #(.RST_VAL(1'b0)) u_field_edge (
        .clk_i(cam_pclk), .rst_i(cam_reset), .sig_i(in_field_toggle),
        .rise_o(f_rise), .fall_o(f_fall), .edge_o(f_edge)
    );

    cnt_t              v_start_q, v_len_q, h_start_q, h_len_q;
    cnt_t              v_start_e, v_len_e, h_start_e, h_len_e;
    cnt_t              line_idx_q, line_idx_e, line_idx_d;
    cnt_t              pix_idx_q, pix_e, pix_idx_d;
    sum_t              v_end, h_end;
    logic              line_en_q, line_en_d;
    logic              sof_armed_q, sof_armed_e, sof_armed_d;
    logic              field_ok_q, field_ok_e;
    logic              out_field_q, out_field_d;
    logic              out_lv_q, out_lv_d;
    logic              out_yv_q, out_yv_d;
    logic [DATA_W-1:0] out_y_q, out_y_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eol_q, out_eol_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              pix_stb, pass, short_line;

    // A field boundary takes effect before a line start seen in the same cycle.
    always_comb begin
        v_start_e   = f_edge ? cfg_v_start : v_start_q;
        v_len_e     = f_edge ? cfg_v_len   : v_len_q;
        h_start_e   = f_edge ? cfg_h_start : h_start_q;
        h_len_e     = f_edge ? cfg_h_len   : h_len_q;
        line_idx_e  = f_edge ? '0 : line_idx_q;
        field_ok_e  = f_edge ? (SEL_BOTH | (SEL_EVEN & f_fall) | (SEL_ODD & f_rise)) : field_ok_q;
        sof_armed_e = f_edge | sof_armed_q;
        v_end       = ext(v_start_e) + ext(v_len_e);
        h_end       = ext(h_start_e) + ext(h_len_e);

        // NOTE: every conditionally updated signal gets its default first, so no latch is inferred.
        line_en_d  = line_en_q & ~f_edge;
        line_idx_d = line_idx_e;
        if (lv_rise) begin
            line_en_d  = field_ok_e && (line_idx_e >= v_start_e) && (ext(line_idx_e) < v_end);
            line_idx_d = sat_inc(line_idx_e);
        end

        pix_e     = lv_edge ? '0 : pix_idx_q;
        pix_idx_d = pix_e;
        pix_stb   = in_y_valid & in_line_valid;
        pass      = pix_stb && line_en_d && (pix_e >= h_start_e) && (ext(pix_e) < h_end);
        if (pix_stb) begin
            pix_idx_d = sat_inc(pix_e);
        end

        sof_armed_d = sof_armed_e & ~pass;
        short_line  = lv_fall && line_en_q && (h_len_e != '0) && (ext(pix_idx_q) < h_end);
        err_d       = short_line;
        err_cnt_d   = (short_line && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

        out_lv_d    = in_line_valid & line_en_d;
        out_yv_d    = pass;
        out_y_d     = pass ? in_y : out_y_q;
        out_sof_d   = pass & sof_armed_e;
        out_eol_d   = pass && (ext(pix_e) == h_end - sum_t'(1));
        out_field_d = f_edge ? in_field_toggle : out_field_q;
    end

    always_ff @(posedge cam_pclk or posedge cam_reset) begin
        if (cam_reset) begin
            v_start_q   <= cnt_t'(DEF_V_START);
            v_len_q     <= cnt_t'(DEF_V_LEN);
            h_start_q   <= cnt_t'(DEF_H_START);
            h_len_q     <= cnt_t'(DEF_H_LEN);
            line_idx_q  <= '0;
            pix_idx_q   <= '0;
            line_en_q   <= 1'b0;
            sof_armed_q <= 1'b1;
            field_ok_q  <= SEL_BOTH | SEL_EVEN;
            out_field_q <= 1'b0;
            out_lv_q    <= 1'b0;
            out_yv_q    <= 1'b0;
            out_y_q     <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            v_start_q   <= v_start_e;
            v_len_q     <= v_len_e;
            h_start_q   <= h_start_e;
            h_len_q     <= h_len_e;
            line_idx_q  <= line_idx_d;
            pix_idx_q   <= pix_idx_d;
            line_en_q   <= line_en_d;
            sof_armed_q <= sof_armed_d;
            field_ok_q  <= field_ok_e;
            out_field_q <= out_field_d;
            out_lv_q    <= out_lv_d;
            out_yv_q    <= out_yv_d;
            out_y_q     <= out_y_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_line_valid = out_lv_q;
    assign out_y_valid    = out_yv_q;
    assign out_y          = out_y_q;
    assign out_sof        = out_sof_q;
    assign out_eol        = out_eol_q;
    assign out_field      = out_field_q;
    assign err_short_line = err_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_cam_crop_window.sv
// Directed bench for cam_crop_window: table of whole-field scenarios plus
// hand-written sequences for short lines, coincident edges and mid-line reset.
module tb_cam_crop_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        lv, yv, tog, tog_nx;
    logic [7:0]  y;
    logic [10:0] cvs, cvl, chs, chl;

    logic       o_lv, o_yv, o_sof, o_eol, o_field, o_err;
    logic [7:0] o_y, o_errcnt;
    logic       s_lv, s_yv, s_sof, s_eol, s_field, s_err;
    logic [7:0] s_y, s_errcnt;

    always #5 clk = ~clk;

    // Scaled default window (24 lines x 48 pixels) keeps whole-field runs short.
    cam_crop_window #(.DEF_V_LEN(24), .DEF_H_LEN(48), .FIELD_SEL(0)) u_dut (
        .cam_pclk(clk), .cam_reset(rst), .in_line_valid(lv), .in_y_valid(yv), .in_y(y),
        .in_field_toggle(tog), .cfg_v_start(cvs), .cfg_v_len(cvl), .cfg_h_start(chs),
        .cfg_h_len(chl), .out_line_valid(o_lv), .out_y_valid(o_yv), .out_y(o_y),
        .out_sof(o_sof), .out_eol(o_eol), .out_field(o_field), .err_short_line(o_err),
        .err_count(o_errcnt)
    );

    cam_crop_window #(.DEF_V_LEN(24), .DEF_H_LEN(48), .FIELD_SEL(1)) u_dut_sel (
        .cam_pclk(clk), .cam_reset(rst), .in_line_valid(lv), .in_y_valid(yv), .in_y(y),
        .in_field_toggle(tog), .cfg_v_start(cvs), .cfg_v_len(cvl), .cfg_h_start(chs),
        .cfg_h_len(chl), .out_line_valid(s_lv), .out_y_valid(s_yv), .out_y(s_y),
        .out_sof(s_sof), .out_eol(s_eol), .out_field(s_field), .err_short_line(s_err),
        .err_count(s_errcnt)
    );

    typedef struct {
        int strobes, sof_n, sof_bad, eol_n, eol_pix;
        int first_line, last_line, first_pix, last_pix;
        int lines_out, lat_bad, err_n, sel_strobes, sel_lv;
    } stats_t;

    typedef struct {
        int tog, vs, vl, hs, hl, mid;
        int e_lines, e_strobes, e_fl, e_ll, e_fp, e_lp, e_eoln, e_eolp, e_sof, e_errcnt, e_sel;
    } row_t;

    stats_t st;
    row_t   tbl[7];
    int     n_checks = 0;
    int     n_err    = 0;
    int     p_line, p_pix;
    logic   prev_olv;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Outputs seen at this negedge belong to the inputs tagged p_line/p_pix.
    task automatic sample();
        if (o_lv && !prev_olv) st.lines_out++;
        prev_olv = o_lv;
        if (o_yv) begin
            if (!o_lv || o_y != 8'(p_pix)) st.lat_bad++;
            if (st.strobes == 0) begin
                st.first_line = p_line;
                st.first_pix  = p_pix;
            end
            st.last_line = p_line;
            st.last_pix  = p_pix;
            if (o_sof) begin
                st.sof_n++;
                if (st.strobes != 0) st.sof_bad++;
            end
            if (o_eol) begin
                st.eol_n++;
                st.eol_pix = p_pix;
            end
            st.strobes++;
        end else if (o_sof || o_eol) begin
            st.sof_bad++;
        end
        if (o_err) st.err_n++;
        if (s_yv) begin
            st.sel_strobes++;
            if (s_y != 8'(p_pix)) st.lat_bad++;
        end
        if (s_lv) st.sel_lv++;
    endtask

    task automatic step(input logic l, input logic v, input int tl, input int tp);
        @(negedge clk);
        sample();
        tog    = tog_nx;
        lv     = l;
        yv     = v;
        y      = 8'(tp);
        p_line = tl;
        p_pix  = tp;
    endtask

    task automatic send_line(input int ln, input int npix);
        step(1'b1, 1'b0, ln, 0);
        for (int p = 0; p < npix; p++) step(1'b1, 1'b1, ln, p);
        repeat (3) step(1'b0, 1'b0, ln, 0);
    endtask

    task automatic run_row(input int i);
        row_t r;
        r      = tbl[i];
        cvs    = 11'(r.vs);
        cvl    = 11'(r.vl);
        chs    = 11'(r.hs);
        chl    = 11'(r.hl);
        tog_nx = (r.tog != 0);
        repeat (2) step(1'b0, 1'b0, -1, 0);
        st = '{default: 0};
        for (int ln = 0; ln < 30; ln++) begin
            if (r.mid != 0 && ln == 5) begin
                cvs = 11'd5; cvl = 11'd10; chs = 11'd8; chl = 11'd32;
            end
            send_line(ln, 48);
        end
        check($sformatf("row%0d strobes", i), st.strobes, r.e_strobes);
        check($sformatf("row%0d sof count", i), st.sof_n, r.e_sof);
        check($sformatf("row%0d marker misalign", i), st.sof_bad, 0);
        check($sformatf("row%0d eol count", i), st.eol_n, r.e_eoln);
        check($sformatf("row%0d latency", i), st.lat_bad, 0);
        check($sformatf("row%0d err_count", i), int'(o_errcnt), r.e_errcnt);
        check($sformatf("row%0d sel strobes", i), st.sel_strobes, r.e_sel);
        check($sformatf("row%0d out_field", i), int'(o_field), r.tog);
        if (r.e_sel == 0) check($sformatf("row%0d sel line_valid", i), st.sel_lv, 0);
        if (r.e_lines >= 0) check($sformatf("row%0d lines out", i), st.lines_out, r.e_lines);
        if (r.e_eoln > 0) check($sformatf("row%0d eol pixel", i), st.eol_pix, r.e_eolp);
        if (r.e_strobes > 0) begin
            check($sformatf("row%0d first line", i), st.first_line, r.e_fl);
            check($sformatf("row%0d last line", i), st.last_line, r.e_ll);
            check($sformatf("row%0d first pixel", i), st.first_pix, r.e_fp);
            check($sformatf("row%0d last pixel", i), st.last_pix, r.e_lp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //         tog vs  vl    hs  hl    mid lines strb  fl  ll  fp  lp  eoln eolp sof err sel
        tbl[0] = '{0,  0,  0,    0,  0,    0,  24,   1152, 0,  23, 0,  47, 24,  47,  1,  0,  1152};
        tbl[1] = '{1,  2,  10,   4,  16,   1,  10,   160,  2,  11, 4,  19, 10,  19,  1,  0,  0};
        tbl[2] = '{0,  5,  10,   8,  32,   0,  10,   320,  5,  14, 8,  39, 10,  39,  1,  0,  320};
        tbl[3] = '{1,  28, 5,    40, 20,   0,  2,    16,   28, 29, 40, 47, 0,   -1,  1,  2,  0};
        tbl[4] = '{0,  0,  0,    0,  48,   0,  0,    0,    -1, -1, -1, -1, 0,   -1,  0,  2,  0};
        tbl[5] = '{1,  0,  30,   10, 0,    0,  -1,   0,    -1, -1, -1, -1, 0,   -1,  0,  2,  0};
        tbl[6] = '{0,  29, 2047, 40, 2040, 0,  1,    8,    29, 29, 40, 47, 0,   -1,  1,  3,  8};

        rst = 1'b1; lv = 1'b0; yv = 1'b0; y = '0; tog = 1'b0; tog_nx = 1'b0;
        cvs = '0; cvl = '0; chs = '0; chl = '0;
        p_line = -1; p_pix = 0; prev_olv = 1'b0;
        st = '{default: 0};
        repeat (3) @(negedge clk);
        check("reset out_line_valid", int'(o_lv), 0);
        check("reset out_y_valid", int'(o_yv), 0);
        check("reset out_y", int'(o_y), 0);
        check("reset out_sof", int'(o_sof), 0);
        check("reset out_eol", int'(o_eol), 0);
        check("reset out_field", int'(o_field), 0);
        check("reset err_short_line", int'(o_err), 0);
        check("reset err_count", int'(o_errcnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_row(i);

        // Short lines and err_count saturation (count is 3 on entry).
        cvs = 11'd0; cvl = 11'd2047; chs = 11'd0; chl = 11'd48;
        tog_nx = 1'b1;
        repeat (2) step(1'b0, 1'b0, -1, 0);
        st = '{default: 0};
        send_line(0, 30);
        check("short line pulse cycles", st.err_n, 1);
        check("short line err_count", int'(o_errcnt), 4);
        send_line(1, 48);
        check("full line no pulse", st.err_n, 1);
        check("full line err_count", int'(o_errcnt), 4);
        for (int k = 0; k < 250; k++) send_line(2 + k, 1);
        check("err_count before saturation", int'(o_errcnt), 254);
        send_line(252, 1);
        check("err_count reaches 255", int'(o_errcnt), 255);
        for (int k = 0; k < 4; k++) send_line(253 + k, 1);
        check("err_count stays 255", int'(o_errcnt), 255);

        // Field toggle coincident with line start: new shadows, line index 0.
        cvs = 11'd0; cvl = 11'd1; chs = 11'd3; chl = 11'd5;
        tog_nx = 1'b0;
        st = '{default: 0};
        send_line(0, 10);
        check("coincident strobes", st.strobes, 5);
        check("coincident first pixel", st.first_pix, 3);
        check("coincident last pixel", st.last_pix, 7);
        check("coincident eol pixel", st.eol_pix, 7);
        check("coincident sof", st.sof_n, 1);
        send_line(1, 10);
        check("coincident next line blocked", st.strobes, 5);

        // Asynchronous reset in the middle of a pixel burst.
        cvs = 11'd0; cvl = 11'd24; chs = 11'd0; chl = 11'd48;
        tog_nx = 1'b1;
        repeat (2) step(1'b0, 1'b0, -1, 0);
        step(1'b1, 1'b0, 0, 0);
        for (int p = 0; p < 20; p++) step(1'b1, 1'b1, 0, p);
        check("pre-reset out_y_valid", int'(o_yv), 1);
        #2 rst = 1'b1;
        #1;
        check("mid-reset out_y_valid", int'(o_yv), 0);
        check("mid-reset out_line_valid", int'(o_lv), 0);
        check("mid-reset out_y", int'(o_y), 0);
        check("mid-reset err_count", int'(o_errcnt), 0);
        for (int p = 20; p < 22; p++) step(1'b1, 1'b1, 0, p);
        rst = 1'b0;
        st = '{default: 0};
        for (int p = 22; p < 40; p++) step(1'b1, 1'b1, 0, p);
        repeat (3) step(1'b0, 1'b0, 0, 0);
        check("post-reset line blocked", st.strobes, 0);
        check("post-reset line_valid blocked", st.lines_out, 0);
        check("post-reset no short error", int'(o_errcnt), 0);
        send_line(1, 48);
        check("resume strobes", st.strobes, 48);
        check("resume lines out", st.lines_out, 1);
        check("resume latency", st.lat_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
